// File: rtl/peripheral_bus_pkg.sv
// peripheral_bus_pkg: shared types and widths for the peripheral bus arbiter
package peripheral_bus_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
endpackage

// File: rtl/peripheral_bus_arbiter_bus_rr_picker.sv
// bus_rr_picker: two-input round-robin select; ties go to the master opposite last_grant
module bus_rr_picker import peripheral_bus_pkg::*; (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_index
);
  always_comb begin
    grant_valid = |eligible;
    grant_index = &eligible ? ~last_grant : (eligible[MASTER_DMA] ? MASTER_DMA : MASTER_CPU);
  end
endmodule

// File: rtl/peripheral_bus_arbiter.sv
// peripheral_bus_arbiter: CPU/DMA arbiter onto a registered valid/ready bus; watchdog under PERIPHERAL_BUS_TIMEOUT_EN
module peripheral_bus_arbiter import peripheral_bus_pkg::*; #(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
  input  logic              clk_2x,
  input  logic              reset_n,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [STRB_W-1:0] cpu_wstrb,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_read_data,
  input  logic              dma_valid,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic [STRB_W-1:0] dma_wstrb,
  input  logic [DATA_W-1:0] dma_write_data,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_read_data,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_address,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [DATA_W-1:0] bus_write_data,
  output logic              bus_grant,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_read_data,
  output logic              timeout_flag,
  input  logic              timeout_clear
);
  state_t            state;
  logic              last_grant;
  logic [1:0]        block;
  logic [1:0]        eligible;
  logic              grant_valid, grant_index;
  logic              forced, done;
  logic [DATA_W-1:0] ret_data;
  assign eligible = {dma_valid & ~block[MASTER_DMA], cpu_valid & ~block[MASTER_CPU]};
  bus_rr_picker u_picker (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant_index(grant_index)
  );
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
  logic [15:0] wd_cnt;
  assign forced = state == ACTIVE && !bus_ready && wd_cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_2x or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wd_cnt       <= state == ACTIVE ? wd_cnt + 16'd1 : 16'd0;
      timeout_flag <= forced | (timeout_flag & ~timeout_clear);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg   = timeout_clear ^ (^TIMEOUT_DATA) ^ (TIMEOUT_CYCLES == 0);
  assign forced       = 1'b0;
  assign timeout_flag = 1'b0;
`endif
  assign done     = state == ACTIVE && (bus_ready || forced);
  assign ret_data = forced ? TIMEOUT_DATA : bus_read_data;
  always_ff @(posedge clk_2x or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      last_grant     <= MASTER_DMA;
      block          <= '0;
      cpu_ready      <= 1'b0;
      cpu_read_data  <= '0;
      dma_ready      <= 1'b0;
      dma_read_data  <= '0;
      bus_valid      <= 1'b0;
      bus_address    <= '0;
      bus_wstrb      <= '0;
      bus_write_data <= '0;
      bus_grant      <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      dma_ready <= 1'b0;
      block     <= block & {dma_valid, cpu_valid};
      if (state == IDLE && grant_valid) begin
        state          <= ACTIVE;
        bus_valid      <= 1'b1;
        bus_grant      <= grant_index;
        last_grant     <= grant_index;
        bus_address    <= grant_index ? dma_address : cpu_address;
        bus_wstrb      <= grant_index ? dma_wstrb : cpu_wstrb;
        bus_write_data <= grant_index ? dma_write_data : cpu_write_data;
      end else if (done) begin
        state            <= IDLE;
        bus_valid        <= 1'b0;
        block[bus_grant] <= 1'b1;
        if (bus_grant) begin
          dma_ready     <= 1'b1;
          dma_read_data <= ret_data;
        end else begin
          cpu_ready     <= 1'b1;
          cpu_read_data <= ret_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// tb_peripheral_bus_arbiter: directed checks of grant, completion, blocking, reset and optional watchdog
module tb_peripheral_bus_arbiter;
  logic        clk_2x = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_valid = 1'b0, dma_valid = 1'b0;
  logic [31:0] cpu_address = '0, dma_address = '0, cpu_write_data = '0, dma_write_data = '0;
  logic [3:0]  cpu_wstrb = '0, dma_wstrb = '0;
  logic        cpu_ready, dma_ready, bus_valid, bus_grant, timeout_flag;
  logic [31:0] cpu_read_data, dma_read_data, bus_address, bus_write_data;
  logic [3:0]  bus_wstrb;
  logic        bus_ready = 1'b0, timeout_clear = 1'b0;
  logic [31:0] bus_read_data = '0;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk_2x = ~clk_2x;

  peripheral_bus_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hFFFF_FFFF)) dut (
    .clk_2x(clk_2x), .reset_n(reset_n),
    .cpu_valid(cpu_valid), .cpu_address(cpu_address), .cpu_wstrb(cpu_wstrb),
    .cpu_write_data(cpu_write_data), .cpu_ready(cpu_ready), .cpu_read_data(cpu_read_data),
    .dma_valid(dma_valid), .dma_address(dma_address), .dma_wstrb(dma_wstrb),
    .dma_write_data(dma_write_data), .dma_ready(dma_ready), .dma_read_data(dma_read_data),
    .bus_valid(bus_valid), .bus_address(bus_address), .bus_wstrb(bus_wstrb),
    .bus_write_data(bus_write_data), .bus_grant(bus_grant), .bus_ready(bus_ready),
    .bus_read_data(bus_read_data), .timeout_flag(timeout_flag), .timeout_clear(timeout_clear)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2x);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_2x);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_bus_valid", 32'(bus_valid), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_dma_rdata", dma_read_data, 0);
    chk("rst_tflag", 32'(timeout_flag), 0);
    // CPU read, slave answers after two cycles
    cpu_valid = 1'b1; cpu_address = 32'h0000_1000; cpu_wstrb = 4'h0;
    step();
    chk("t1_bus_valid", 32'(bus_valid), 1);
    chk("t1_grant", 32'(bus_grant), 0);
    chk("t1_addr", bus_address, 32'h0000_1000);
    chk("t1_wstrb", 32'(bus_wstrb), 0);
    step();
    chk("t1_wait_valid", 32'(bus_valid), 1);
    chk("t1_wait_ready", 32'(cpu_ready), 0);
    bus_ready = 1'b1; bus_read_data = 32'h1234_5678;
    step();
    bus_ready = 1'b0; bus_read_data = '0;
    chk("t1_ready", 32'(cpu_ready), 1);
    chk("t1_rdata", cpu_read_data, 32'h1234_5678);
    chk("t1_bus_drop", 32'(bus_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t1_no_reissue", 32'(bus_valid), 0);
      chk("t1_single_pulse", 32'(cpu_ready), 0);
    end
    chk("t1_rdata_held", cpu_read_data, 32'h1234_5678);
    cpu_valid = 1'b0;
    // simultaneous requests after reset: CPU first, DMA next, then alternate
    do_reset();
    cpu_valid = 1'b1; cpu_address = 32'hC000_0004;
    dma_valid = 1'b1; dma_address = 32'hD000_0008; dma_wstrb = 4'hF; dma_write_data = 32'hA5A5_0F0F;
    step();
    chk("t2_first_grant", 32'(bus_grant), 0);
    chk("t2_first_addr", bus_address, 32'hC000_0004);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0; cpu_valid = 1'b0;
    chk("t2_cpu_ready", 32'(cpu_ready), 1);
    chk("t2_gap", 32'(bus_valid), 0);
    step();
    chk("t2_dma_valid", 32'(bus_valid), 1);
    chk("t2_dma_grant", 32'(bus_grant), 1);
    chk("t2_dma_addr", bus_address, 32'hD000_0008);
    chk("t2_dma_wstrb", 32'(bus_wstrb), 32'hF);
    chk("t2_dma_wdata", bus_write_data, 32'hA5A5_0F0F);
    bus_ready = 1'b1; bus_read_data = 32'h0000_BEEF;
    step();
    bus_ready = 1'b0; dma_valid = 1'b0;
    chk("t2_dma_ready", 32'(dma_ready), 1);
    chk("t2_no_cpu_ready", 32'(cpu_ready), 0);
    chk("t2_dma_rdata", dma_read_data, 32'h0000_BEEF);
    step();
    cpu_valid = 1'b1; dma_valid = 1'b1;
    step();
    chk("t2_alt_cpu", 32'(bus_grant), 0);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0; cpu_valid = 1'b0;
    step();
    chk("t2_alt_dma_valid", 32'(bus_valid), 1);
    chk("t2_alt_dma", 32'(bus_grant), 1);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0; dma_valid = 1'b0;
    step();
    // CPU keeps valid high after ready while DMA requests
    cpu_valid = 1'b1; cpu_address = 32'h0000_2000;
    step();
    chk("t3_cpu_grant", 32'(bus_grant), 0);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0; dma_valid = 1'b1;
    chk("t3_cpu_ready", 32'(cpu_ready), 1);
    step();
    chk("t3_dma_valid", 32'(bus_valid), 1);
    chk("t3_dma_grant", 32'(bus_grant), 1);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0; dma_valid = 1'b0;
    step();
    chk("t3_cpu_blocked_a", 32'(bus_valid), 0);
    step();
    chk("t3_cpu_blocked_b", 32'(bus_valid), 0);
    cpu_valid = 1'b0;
    step();
    chk("t3_cpu_low", 32'(bus_valid), 0);
    cpu_valid = 1'b1;
    step();
    chk("t3_cpu_regrant", 32'(bus_valid), 1);
    chk("t3_cpu_regrant_idx", 32'(bus_grant), 0);
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0; cpu_valid = 1'b0;
    step();
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    // silent slave: forced completion after 8 cycles
    cpu_valid = 1'b1; cpu_address = 32'h0000_3000;
    step();
    chk("t4_valid", 32'(bus_valid), 1);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t4_wait", 32'(cpu_ready), 0);
    end
    step();
    cpu_valid = 1'b0;
    chk("t4_ready", 32'(cpu_ready), 1);
    chk("t4_rdata", cpu_read_data, 32'hFFFF_FFFF);
    chk("t4_flag", 32'(timeout_flag), 1);
    chk("t4_bus_drop", 32'(bus_valid), 0);
    step();
    chk("t4_flag_sticky", 32'(timeout_flag), 1);
    timeout_clear = 1'b1;
    step();
    timeout_clear = 1'b0;
    chk("t4_flag_cleared", 32'(timeout_flag), 0);
    // bus_ready lands exactly on the expiry cycle
    cpu_valid = 1'b1;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("t5_before", 32'(cpu_ready), 0);
    bus_ready = 1'b1; bus_read_data = 32'hCAFE_0001;
    step();
    bus_ready = 1'b0; cpu_valid = 1'b0;
    chk("t5_ready", 32'(cpu_ready), 1);
    chk("t5_rdata", cpu_read_data, 32'hCAFE_0001);
    chk("t5_flag", 32'(timeout_flag), 0);
    step();
`endif
    // reset during an access
    dma_valid = 1'b1; dma_address = 32'hD000_0010;
    step();
    chk("t6_dma_valid", 32'(bus_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus_valid), 0);
    chk("t6_async_addr", bus_address, 0);
    chk("t6_async_cpu_rdata", cpu_read_data, 0);
    chk("t6_async_dma_rdata", dma_read_data, 0);
    step();
    chk("t6_no_ready", 32'(dma_ready), 0);
    reset_n = 1'b1;
    step();
    chk("t6_fresh_valid", 32'(bus_valid), 1);
    chk("t6_fresh_grant", 32'(bus_grant), 1);
    chk("t6_fresh_addr", bus_address, 32'hD000_0010);
    bus_ready = 1'b1; bus_read_data = 32'h0BAD_F00D;
    step();
    bus_ready = 1'b0; dma_valid = 1'b0;
    chk("t6_fresh_ready", 32'(dma_ready), 1);
    chk("t6_fresh_rdata", dma_read_data, 32'h0BAD_F00D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
